div42x16: RTL and testbench



---
 rtl/div42x16_pkg.sv | 18 +
 rtl/div42x16_step.sv | 26 ++
 rtl/div42x16.sv | 159 +++++++++++++++
 tb/tb_div42x16.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div42x16_pkg.sv
// Shared constants and types for the div42x16 iterative divider.
package div42x16_pkg;

  localparam int unsigned DwDefault = 42;
  localparam int unsigned VwDefault = 16;
  localparam int unsigned QwDefault = 26;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFix,
    StDone
  } state_e;

  localparam logic [QwDefault-1:0] QMAX = 26'h1FFFFFF;
  localparam logic [QwDefault-1:0] QMIN = 26'h2000000;

endpackage

// File: rtl/div42x16_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module div42x16_step #(
  parameter int unsigned VW = div42x16_pkg::VwDefault
) (
  input  logic [VW:0]   rem,
  input  logic          din,
  input  logic [VW-1:0] divisor,
  output logic [VW:0]   rem_next,
  output logic          qbit
);

  logic [VW+1:0] shifted;
  logic [VW+1:0] trial;
  logic          unused_msb;

  // The incoming remainder is always below the divisor, so the top bit of trial is never needed.
  always_comb begin
    shifted  = {rem, din};
    qbit     = (shifted >= {2'b00, divisor});
    trial    = qbit ? (shifted - {2'b00, divisor}) : shifted;
    rem_next = trial[VW:0];
  end

  assign unused_msb = trial[VW+1];

endmodule

// File: rtl/div42x16.sv
// Iterative signed-by-unsigned divider with saturated quotient and dividend-signed remainder.
// Define DIV42X16_ROUND_EN to round the quotient magnitude to nearest, half away from zero.
module div42x16
  import div42x16_pkg::*;
#(
  parameter int unsigned DW = DwDefault,
  parameter int unsigned VW = VwDefault,
  parameter int unsigned QW = QwDefault
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [QW-1:0] quotient,
  output logic [VW:0]   remainder,
  output logic          ovf,
  output logic          dz
);

  localparam int unsigned CntW = $clog2(DW);
  localparam logic [QW-1:0] QPos = {1'b0, {(QW-1){1'b1}}};
  localparam logic [QW-1:0] QNeg = {1'b1, {(QW-1){1'b0}}};
  localparam logic [DW-1:0] PosLim = {{(DW-QW+1){1'b0}}, {(QW-1){1'b1}}};
  localparam logic [DW-1:0] NegLim = PosLim + DW'(1);

  state_e        state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  // Dividend magnitude shifts out MSB first while quotient bits shift in at the bottom.
  logic [DW-1:0] mag_q, mag_d;
  logic [VW:0]   rem_q, rem_d;
  logic [VW-1:0] dvs_q, dvs_d;
  logic          sign_q, sign_d;
  logic [QW-1:0] quot_q, quot_d;
  logic [VW:0]   remo_q, remo_d;
  logic          ovf_q, ovf_d;
  logic          dz_q, dz_d;

  logic [VW:0]   step_rem;
  logic          step_qbit;
  logic [DW-1:0] qmag;

  div42x16_step #(
    .VW(VW)
  ) u_step (
    .rem      (rem_q),
    .din      (mag_q[DW-1]),
    .divisor  (dvs_q),
    .rem_next (step_rem),
    .qbit     (step_qbit)
  );

  always_comb begin
`ifdef DIV42X16_ROUND_EN
    qmag = ({rem_q, 1'b0} >= {2'b00, dvs_q}) ? (mag_q + DW'(1)) : mag_q;
`else
    qmag = mag_q;
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mag_d   = mag_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    sign_d  = sign_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
    ovf_d   = ovf_q;
    dz_d    = dz_q;

    case (state_q)
      StIdle: begin
        if (in_valid) begin
          sign_d  = dividend[DW-1];
          mag_d   = dividend[DW-1] ? -dividend : dividend;
          dvs_d   = divisor;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = (divisor == '0) ? StFix : StCalc;
        end
      end
      StCalc: begin
        mag_d = {mag_q[DW-2:0], step_qbit};
        rem_d = step_rem;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(DW - 1)) begin
          state_d = StFix;
        end
      end
      StFix: begin
        state_d = StDone;
        if (dvs_q == '0) begin
          quot_d = sign_q ? QNeg : QPos;
          remo_d = '0;
          ovf_d  = 1'b0;
          dz_d   = 1'b1;
        end else begin
          dz_d   = 1'b0;
          remo_d = sign_q ? -rem_q : rem_q;
          if (!sign_q && (qmag > PosLim)) begin
            quot_d = QPos;
            ovf_d  = 1'b1;
          end else if (sign_q && (qmag > NegLim)) begin
            quot_d = QNeg;
            ovf_d  = 1'b1;
          end else begin
            quot_d = sign_q ? -qmag[QW-1:0] : qmag[QW-1:0];
            ovf_d  = 1'b0;
          end
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      mag_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      sign_q  <= 1'b0;
      quot_q  <= '0;
      remo_q  <= '0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mag_q   <= mag_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      sign_q  <= sign_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign quotient  = quot_q;
  assign remainder = remo_q;
  assign ovf       = ovf_q;
  assign dz        = dz_q;

endmodule

// File: tb/tb_div42x16.sv
// Self-checking bench for div42x16: directed corner cases plus randomized operands
// checked against an arithmetic reference model.
module tb_div42x16;
  import div42x16_pkg::*;

`ifdef DIV42X16_ROUND_EN
  localparam bit Rnd = 1'b1;
`else
  localparam bit Rnd = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [41:0] dividend = '0;
  logic [15:0] divisor = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [25:0] quotient;
  logic [16:0] remainder;
  logic        ovf;
  logic        dz;

  int checks = 0;
  int errors = 0;

  typedef struct {
    longint a;
    longint b;
    longint q;
    longint r;
    bit     o;
    bit     z;
    int     lat;
  } vec_t;

  always #5 clk = ~clk;

  div42x16 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .ovf       (ovf),
    .dz        (dz)
  );

  // Reference: plain signed integer division (truncating), optional rounding, then saturation.
  function automatic void model(input logic [41:0] a, input logic [15:0] b,
                                output logic [25:0] q, output logic [16:0] r,
                                output logic o, output logic z);
    longint sa, qq, rr, qm, rm;
    bit neg;
    sa  = longint'($signed(a));
    neg = (sa < 0);
    if (b == 16'd0) begin
      q = neg ? QMIN : QMAX;
      r = '0;
      o = 1'b0;
      z = 1'b1;
      return;
    end
    qq = sa / longint'(b);
    rr = sa % longint'(b);
    qm = (qq < 0) ? -qq : qq;
    rm = (rr < 0) ? -rr : rr;
    if (Rnd && (2 * rm >= longint'(b))) qm = qm + 1;
    z = 1'b0;
    if (!neg && qm > 33554431) begin
      q = QMAX;
      o = 1'b1;
    end else if (neg && qm > 33554432) begin
      q = QMIN;
      o = 1'b1;
    end else begin
      q = 26'(neg ? -qm : qm);
      o = 1'b0;
    end
    r = rr[16:0];
  endfunction

  function automatic logic [41:0] rand_dividend();
    logic [63:0] x;
    x = {$urandom(), $urandom()};
    case ($urandom_range(0, 2))
      0:       return x[41:0];
      1:       return 42'($signed(x[20:0]));
      default: return 42'($signed(x[35:0]));
    endcase
  endfunction

  function automatic logic [15:0] rand_divisor(input bit allow_zero);
    logic [15:0] x;
    x = 16'($urandom());
    case ($urandom_range(0, 9))
      0:       return allow_zero ? 16'd0 : 16'd3;
      1:       return 16'd1;
      2:       return {10'd0, x[5:0]} + 16'd1;
      default: return (x == 16'd0) ? 16'd65535 : x;
    endcase
  endfunction

  // Accepts one operation at the next edge and waits (bounded) for out_valid.
  // At lat == poke a spurious in_valid with a zero divisor is driven for one cycle.
  task automatic start_and_wait(input logic [41:0] a, input logic [15:0] b, input int poke,
                                output int lat);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = 42'({$urandom(), $urandom()});
    divisor  = 16'($urandom());
    lat = 0;
    while (!out_valid && lat < 100) begin
      if (lat == poke) begin
        in_valid = 1'b1;
        divisor  = 16'd0;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    in_valid = 1'b0;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid got %b want 0", out_valid); end
    checks++; if (quotient !== 26'd0) begin errors++; $display("FAIL reset quotient got %h want 0", quotient); end
    checks++; if (remainder !== 17'd0) begin errors++; $display("FAIL reset remainder got %h want 0", remainder); end
    checks++; if ({ovf, dz} !== 2'b00) begin errors++; $display("FAIL reset ovf/dz got %b%b want 00", ovf, dz); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    vec_t v[$];
    int lat;
    v.push_back('{1000, 7, Rnd ? 143 : 142, 6, 1'b0, 1'b0, 43});
    v.push_back('{-1000, 7, Rnd ? -143 : -142, -6, 1'b0, 1'b0, 43});
    v.push_back('{5, 0, 33554431, 0, 1'b0, 1'b1, 1});
    v.push_back('{-5, 0, -33554432, 0, 1'b0, 1'b1, 1});
    v.push_back('{64'h1FF_FFFF_FFFF, 1, 33554431, 0, 1'b1, 1'b0, 43});
    v.push_back('{-64'sh200_0000_0000, 1, -33554432, 0, 1'b1, 1'b0, 43});
    v.push_back('{-12345 * 999, 999, -12345, 0, 1'b0, 1'b0, 43});
    v.push_back('{999, 2, Rnd ? 500 : 499, 1, 1'b0, 1'b0, 43});
    v.push_back('{-999, 2, Rnd ? -500 : -499, -1, 1'b0, 1'b0, 43});
    v.push_back('{33554431, 1, 33554431, 0, 1'b0, 1'b0, 43});
    v.push_back('{33554432, 1, 33554431, 0, 1'b1, 1'b0, 43});
    v.push_back('{-33554432, 1, -33554432, 0, 1'b0, 1'b0, 43});
    v.push_back('{-33554433, 1, -33554432, 0, 1'b1, 1'b0, 43});
    v.push_back('{0, 5, 0, 0, 1'b0, 1'b0, 43});
    v.push_back('{100000, 65535, Rnd ? 2 : 1, 34465, 1'b0, 1'b0, 43});
    foreach (v[i]) begin
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL dir%0d in_ready got %b want 1", i, in_ready); end
      start_and_wait(42'(v[i].a), 16'(v[i].b), -1, lat);
      checks++; if (lat != v[i].lat) begin errors++; $display("FAIL dir%0d latency got %0d want %0d", i, lat, v[i].lat); end
      checks++; if (quotient !== 26'(v[i].q)) begin errors++; $display("FAIL dir%0d quotient got %h want %h", i, quotient, 26'(v[i].q)); end
      checks++; if (remainder !== 17'(v[i].r)) begin errors++; $display("FAIL dir%0d remainder got %h want %h", i, remainder, 17'(v[i].r)); end
      checks++; if (ovf !== v[i].o) begin errors++; $display("FAIL dir%0d ovf got %b want %b", i, ovf, v[i].o); end
      checks++; if (dz !== v[i].z) begin errors++; $display("FAIL dir%0d dz got %b want %b", i, dz, v[i].z); end
      release_result();
    end
  endtask

  task automatic test_random();
    logic [41:0] a;
    logic [15:0] b;
    logic [25:0] eq;
    logic [16:0] er;
    logic eo, ez;
    int lat;
    for (int i = 0; i < 60; i++) begin
      a = rand_dividend();
      b = rand_divisor(1'b1);
      model(a, b, eq, er, eo, ez);
      start_and_wait(a, b, -1, lat);
      checks++; if (lat != (ez ? 1 : 43)) begin errors++; $display("FAIL rnd%0d latency got %0d want %0d", i, lat, ez ? 1 : 43); end
      checks++; if (quotient !== eq) begin errors++; $display("FAIL rnd%0d quotient a=%h b=%h got %h want %h", i, a, b, quotient, eq); end
      checks++; if (remainder !== er) begin errors++; $display("FAIL rnd%0d remainder a=%h b=%h got %h want %h", i, a, b, remainder, er); end
      checks++; if ({ovf, dz} !== {eo, ez}) begin errors++; $display("FAIL rnd%0d ovf/dz got %b%b want %b%b", i, ovf, dz, eo, ez); end
      release_result();
    end
  endtask

  task automatic test_back_pressure();
    logic [41:0] a;
    logic [15:0] b;
    logic [25:0] eq;
    logic [16:0] er;
    logic eo, ez;
    int lat;
    a = 42'd1000;
    b = 16'd7;
    model(a, b, eq, er, eo, ez);
    start_and_wait(a, b, -1, lat);
    for (int c = 0; c < 10; c++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp%0d out_valid got %b want 1", c, out_valid); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp%0d in_ready got %b want 0", c, in_ready); end
      checks++; if ({quotient, remainder, ovf, dz} !== {eq, er, eo, ez}) begin
        errors++; $display("FAIL bp%0d outputs got %h/%h want %h/%h", c, quotient, remainder, eq, er);
      end
      @(posedge clk);
      #1;
    end
    release_result();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp in_ready after transfer got %b want 1", in_ready); end
  endtask

  task automatic test_ignore_in_valid();
    logic [41:0] a;
    logic [15:0] b;
    logic [25:0] eq;
    logic [16:0] er;
    logic eo, ez;
    int lat;
    a = rand_dividend();
    b = rand_divisor(1'b0);
    model(a, b, eq, er, eo, ez);
    start_and_wait(a, b, 5, lat);
    checks++; if (lat != 43) begin errors++; $display("FAIL poke latency got %0d want 43", lat); end
    checks++; if ({quotient, remainder} !== {eq, er}) begin
      errors++; $display("FAIL poke result got %h/%h want %h/%h", quotient, remainder, eq, er);
    end
    checks++; if (dz !== 1'b0) begin errors++; $display("FAIL poke dz got %b want 0", dz); end
    release_result();
  endtask

  task automatic test_reset_mid_calc();
    logic [25:0] eq;
    logic [16:0] er;
    logic eo, ez;
    int lat;
    start_and_wait(42'd1000, 16'd7, -1, lat);
    release_result();
    dividend = 42'd5000;
    divisor  = 16'd3;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst out_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst in_ready got %b want 1", in_ready); end
    checks++; if ({quotient, remainder, ovf, dz} !== 45'd0) begin
      errors++; $display("FAIL midrst outputs got %h/%h/%b%b want 0", quotient, remainder, ovf, dz);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    model(42'h3FF_FFFF_FC19, 16'd2, eq, er, eo, ez);
    start_and_wait(42'h3FF_FFFF_FC19, 16'd2, -1, lat);
    checks++; if ({quotient, remainder, ovf, dz} !== {eq, er, eo, ez}) begin
      errors++; $display("FAIL midrst recovery got %h/%h want %h/%h", quotient, remainder, eq, er);
    end
    release_result();
  endtask

  task automatic test_back_to_back();
    logic [41:0] a[3];
    logic [15:0] b[3];
    logic [25:0] eq[$];
    logic [16:0] er[$];
    logic [25:0] mq;
    logic [16:0] mr;
    logic mo, mz;
    int acc_cyc[$];
    int nacc = 0;
    int nres = 0;
    bit pend = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a[i] = rand_dividend();
      b[i] = rand_divisor(1'b0);
    end
    @(negedge clk);
    dividend  = a[0];
    divisor   = b[0];
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 400 && nres < 3; cyc++) begin
      if (pend) begin
        pend = 1'b0;
        if (nacc < 3) begin
          dividend = a[nacc];
          divisor  = b[nacc];
        end else begin
          in_valid = 1'b0;
        end
      end
      if (in_valid && in_ready) begin
        model(a[nacc], b[nacc], mq, mr, mo, mz);
        eq.push_back(mq);
        er.push_back(mr);
        acc_cyc.push_back(cyc);
        nacc++;
        pend = 1'b1;
      end
      if (out_valid && eq.size() > 0) begin
        mq = eq.pop_front();
        mr = er.pop_front();
        checks++; if ({quotient, remainder} !== {mq, mr}) begin
          errors++; $display("FAIL b2b%0d result got %h/%h want %h/%h", nres, quotient, remainder, mq, mr);
        end
        nres++;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    checks++; if (nres != 3) begin errors++; $display("FAIL b2b results got %0d want 3", nres); end
    checks++;
    if (acc_cyc.size() != 3) begin
      errors++; $display("FAIL b2b accepts got %0d want 3", acc_cyc.size());
    end else if (acc_cyc[1] - acc_cyc[0] != 45 || acc_cyc[2] - acc_cyc[1] != 45) begin
      errors++; $display("FAIL b2b interval got %0d,%0d want 45,45",
                         acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1]);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_pressure();
    test_ignore_in_valid();
    test_reset_mid_calc();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
